// File: rtl/l15_pkg.sv
// Shared L1.5 message constants, request record and arbiter state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package l15_pkg;

    // Request types issued towards the L1.5
    localparam logic [5:0] LOAD_RQ  = 6'h00;
    localparam logic [5:0] STORE_RQ = 6'h01;
    localparam logic [5:0] IMISS_RQ = 6'h10;

    // Return types coming back from the L1.5
    localparam logic [3:0] LOAD_RET  = 4'h0;
    localparam logic [3:0] IFILL_RET = 4'h1;
    localparam logic [3:0] ST_ACK    = 4'h4;
    localparam logic [3:0] INT_RET   = 4'h7;

    // Request size encodings
    localparam logic [2:0] MSG_DATA_SIZE_0B  = 3'b000;
    localparam logic [2:0] MSG_DATA_SIZE_1B  = 3'b001;
    localparam logic [2:0] MSG_DATA_SIZE_2B  = 3'b010;
    localparam logic [2:0] MSG_DATA_SIZE_4B  = 3'b011;
    localparam logic [2:0] MSG_DATA_SIZE_8B  = 3'b100;
    localparam logic [2:0] MSG_DATA_SIZE_16B = 3'b101;
    localparam logic [2:0] MSG_DATA_SIZE_32B = 3'b110;
    localparam logic [2:0] MSG_DATA_SIZE_64B = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        CL_FETCH = 1'b0,
        CL_MEM   = 1'b1
    } client_e;

    typedef struct packed {
        logic [5:0]  rqtype;
        logic [2:0]  size;
        logic [31:0] address;
        logic [31:0] data;
    } l15_req_t;

    // True when rt is the completion that the outstanding request type expects
    function automatic logic ret_matches(input logic [5:0] rq, input logic [3:0] rt);
        return ((rq == LOAD_RQ)  && (rt == LOAD_RET))  ||
               ((rq == STORE_RQ) && (rt == ST_ACK))    ||
               ((rq == IMISS_RQ) && (rt == IFILL_RET));
    endfunction

endpackage

// File: rtl/l15_port_arb_if.sv
// Bundle of client request/response and L1.5 port signals for the port arbiter.
// Latency: n/a (wiring only).
// Backpressure: val held until rdy pulse on the client side; ack/header_ack on the L1.5 side.
interface l15_port_arb_if;

    // fetch client
    logic        f_req_val;
    logic        f_req_rdy;
    logic [5:0]  f_rqtype;
    logic [2:0]  f_size;
    logic [31:0] f_address;
    logic [31:0] f_data;
    logic        f_resp_val;

    // data-memory client
    logic        m_req_val;
    logic        m_req_rdy;
    logic [5:0]  m_rqtype;
    logic [2:0]  m_size;
    logic [31:0] m_address;
    logic [31:0] m_data;
    logic        m_resp_val;

    // shared response bus
    logic [3:0]  resp_returntype;
    logic [63:0] resp_data_0;
    logic [63:0] resp_data_1;
    logic        resp_err;
    logic        err_sticky;

    // L1.5 port
    logic        core_l15_val;
    logic [5:0]  core_l15_rqtype;
    logic [2:0]  core_l15_size;
    logic [31:0] core_l15_address;
    logic [31:0] core_l15_data;
    logic        l15_core_ack;
    logic        l15_core_header_ack;
    logic        l15_core_val;
    logic [3:0]  l15_core_returntype;
    logic [63:0] l15_core_data_0;
    logic [63:0] l15_core_data_1;
    logic        core_l15_req_ack;

    // arbiter side
    modport master (
        input  f_req_val, f_rqtype, f_size, f_address, f_data,
        input  m_req_val, m_rqtype, m_size, m_address, m_data,
        output f_req_rdy, m_req_rdy, f_resp_val, m_resp_val,
        output resp_returntype, resp_data_0, resp_data_1, resp_err, err_sticky,
        output core_l15_val, core_l15_rqtype, core_l15_size, core_l15_address, core_l15_data,
        input  l15_core_ack, l15_core_header_ack, l15_core_val, l15_core_returntype,
        input  l15_core_data_0, l15_core_data_1,
        output core_l15_req_ack
    );

    // clients + L1.5 side
    modport slave (
        output f_req_val, f_rqtype, f_size, f_address, f_data,
        output m_req_val, m_rqtype, m_size, m_address, m_data,
        input  f_req_rdy, m_req_rdy, f_resp_val, m_resp_val,
        input  resp_returntype, resp_data_0, resp_data_1, resp_err, err_sticky,
        input  core_l15_val, core_l15_rqtype, core_l15_size, core_l15_address, core_l15_data,
        output l15_core_ack, l15_core_header_ack, l15_core_val, l15_core_returntype,
        output l15_core_data_0, l15_core_data_1,
        input  core_l15_req_ack
    );

endinterface

// File: rtl/l15_rr_arb2.sv
// Two-way round-robin grant between fetch and data-memory with a registered priority bit.
// Latency: combinational grant in the enabled cycle; priority updates on the following edge.
// Backpressure: no grant while en is low; a losing requester simply stays pending.
module l15_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_f,
    input  logic req_m,
    output logic gnt_f,
    output logic gnt_m
);

    logic prio_mem_q;
    logic prio_mem_d;

    // Pick a winner; on a grant hand priority to the other client
    always_comb begin
        gnt_f      = 1'b0;
        gnt_m      = 1'b0;
        prio_mem_d = prio_mem_q;
        if (en) begin
            if (req_f && req_m) begin
                gnt_m = prio_mem_q;
                gnt_f = !prio_mem_q;
            end else begin
                gnt_f = req_f;
                gnt_m = req_m;
            end
            if (gnt_f) begin
                prio_mem_d = 1'b1;
            end else if (gnt_m) begin
                prio_mem_d = 1'b0;
            end
        end
    end

    // Priority register; data-memory holds priority out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_mem_q <= 1'b1;
        end else begin
            prio_mem_q <= prio_mem_d;
        end
    end

endmodule

// File: rtl/l15_port_arb.sv
// Arbitrates fetch and data-memory onto the single L1.5 port, one transaction outstanding.
// Latency: rdy at t -> core_l15_val at t+1; l15_core_val at u -> resp_val at u+1.
// Backpressure: clients hold val until rdy; the request is held until ack && header_ack.
module l15_port_arb #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic          clk,
    input  logic          rst,
    l15_port_arb_if.master bus
);
    import l15_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYC);

    arb_state_e  state_q, state_d;
    client_e     owner_q, owner_d;
    l15_req_t    req_q, req_d;
    logic [3:0]  rtype_q, rtype_d;
    logic [63:0] d0_q, d0_d;
    logic [63:0] d1_q, d1_d;
    logic        rerr_q, rerr_d;
    logic        sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] cnt_inc;
    logic        arb_en;
    logic        gnt_f;
    logic        gnt_m;
    logic        req_ack_c;

    // Only arbitrate while idle and out of reset, so a grant is never lost to rst
    assign arb_en = (state_q == ST_IDLE) && !rst;

    l15_rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .req_f (bus.f_req_val),
        .req_m (bus.m_req_val),
        .gnt_f (gnt_f),
        .gnt_m (gnt_m)
    );

    // Next-state, latch updates and response handling
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        req_d     = req_q;
        rtype_d   = rtype_q;
        d0_d      = d0_q;
        d1_d      = d1_q;
        rerr_d    = rerr_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        req_ack_c = 1'b0;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                // stale responses (e.g. from before a reset) are consumed and dropped
                req_ack_c = bus.l15_core_val;
                cnt_d     = '0;
                if (gnt_f) begin
                    owner_d       = CL_FETCH;
                    req_d.rqtype  = bus.f_rqtype;
                    req_d.size    = bus.f_size;
                    req_d.address = bus.f_address;
                    req_d.data    = bus.f_data;
                    rerr_d        = 1'b0;
                    state_d       = ST_REQ;
                end else if (gnt_m) begin
                    owner_d       = CL_MEM;
                    req_d.rqtype  = bus.m_rqtype;
                    req_d.size    = bus.m_size;
                    req_d.address = bus.m_address;
                    req_d.data    = bus.m_data;
                    rerr_d        = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                req_ack_c = bus.l15_core_val;
                cnt_d     = '0;
                if (bus.l15_core_ack && bus.l15_core_header_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d     = cnt_inc;
                req_ack_c = bus.l15_core_val;
                if (bus.l15_core_val && ret_matches(req_q.rqtype, bus.l15_core_returntype)) begin
                    rtype_d = bus.l15_core_returntype;
                    d0_d    = bus.l15_core_data_0;
                    d1_d    = bus.l15_core_data_1;
                    state_d = ST_RESP;
                end else begin
                    // interrupts are silently dropped; anything else is a protocol error
                    if (bus.l15_core_val && (bus.l15_core_returntype != INT_RET)) begin
                        sticky_d = 1'b1;
                    end
                    if ((TIMEOUT_CYC != 0) && (cnt_inc == TO_VAL)) begin
                        sticky_d = 1'b1;
                        rerr_d   = 1'b1;
                        rtype_d  = '0;
                        d0_d     = '0;
                        d1_d     = '0;
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= CL_FETCH;
            req_q    <= '0;
            rtype_q  <= '0;
            d0_q     <= '0;
            d1_q     <= '0;
            rerr_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
            rtype_q  <= rtype_d;
            d0_q     <= d0_d;
            d1_q     <= d1_d;
            rerr_q   <= rerr_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.f_req_rdy        = gnt_f;
    assign bus.m_req_rdy        = gnt_m;
    assign bus.f_resp_val       = (state_q == ST_RESP) && (owner_q == CL_FETCH) && !rst;
    assign bus.m_resp_val       = (state_q == ST_RESP) && (owner_q == CL_MEM) && !rst;
    assign bus.resp_err         = (state_q == ST_RESP) && rerr_q && !rst;
    assign bus.resp_returntype  = rtype_q;
    assign bus.resp_data_0      = d0_q;
    assign bus.resp_data_1      = d1_q;
    assign bus.err_sticky       = sticky_q;
    assign bus.core_l15_val     = (state_q == ST_REQ) && !rst;
    assign bus.core_l15_rqtype  = req_q.rqtype;
    assign bus.core_l15_size    = req_q.size;
    assign bus.core_l15_address = req_q.address;
    assign bus.core_l15_data    = req_q.data;
    assign bus.core_l15_req_ack = req_ack_c && !rst;

endmodule

// File: tb/tb_l15_port_arb.sv
// Bench for l15_port_arb: directed scenarios followed by randomized rounds
// against a transaction-level model of grant order and expected completions.
module tb_l15_port_arb;
    import l15_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l15_port_arb_if bus ();

    l15_port_arb #(.TIMEOUT_CYC(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pending requests per client (0 = fetch, 1 = data-memory)
    bit          pend [2];
    logic [5:0]  c_rq [2];
    logic [2:0]  c_sz [2];
    logic [31:0] c_ad [2];
    logic [31:0] c_dt [2];
    int          pref;
    int          owner;
    bit          exp_sticky;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [3:0] exp_ret(input logic [5:0] rq);
        case (rq)
            LOAD_RQ:  return LOAD_RET;
            STORE_RQ: return ST_ACK;
            default:  return IFILL_RET;
        endcase
    endfunction

    function automatic logic [255:0] all_outs();
        return {43'd0, bus.f_req_rdy, bus.m_req_rdy, bus.f_resp_val, bus.m_resp_val,
                bus.resp_returntype, bus.resp_data_0, bus.resp_data_1, bus.resp_err,
                bus.core_l15_val, bus.core_l15_rqtype, bus.core_l15_size,
                bus.core_l15_address, bus.core_l15_data, bus.core_l15_req_ack, bus.err_sticky};
    endfunction

    task automatic drive_reqs();
        bus.f_req_val = pend[0];
        bus.f_rqtype  = c_rq[0];
        bus.f_size    = c_sz[0];
        bus.f_address = c_ad[0];
        bus.f_data    = c_dt[0];
        bus.m_req_val = pend[1];
        bus.m_rqtype  = c_rq[1];
        bus.m_size    = c_sz[1];
        bus.m_address = c_ad[1];
        bus.m_data    = c_dt[1];
    endtask

    task automatic l15_idle();
        bus.l15_core_ack        = 1'b0;
        bus.l15_core_header_ack = 1'b0;
        bus.l15_core_val        = 1'b0;
        bus.l15_core_returntype = 4'h0;
        bus.l15_core_data_0     = 64'd0;
        bus.l15_core_data_1     = 64'd0;
    endtask

    task automatic do_reset();
        tick();
        rst     = 1'b1;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive_reqs();
        l15_idle();
        sample();
        tick();
        rst = 1'b0;
        sample();
        pref       = 1;
        exp_sticky = 1'b0;
    endtask

    task automatic new_req(input int c, input logic [5:0] rq, input logic [31:0] ad);
        pend[c] = 1'b1;
        c_rq[c] = rq;
        c_sz[c] = 3'($urandom_range(0, 7));
        c_ad[c] = ad;
        c_dt[c] = $urandom;
    endtask

    // Present pending requests, expect the model's winner immediately, then
    // drive the L1.5 accept. Returns positioned in the first WAIT cycle.
    task automatic grant();
        int win;
        int k;
        win = (pend[0] && pend[1]) ? pref : (pend[1] ? 1 : 0);
        tick();
        drive_reqs();
        sample();
        k = 0;
        while (!(bus.f_req_rdy || bus.m_req_rdy) && k < 10) begin
            tick();
            sample();
            k++;
        end
        chk("grant_who", {bus.f_req_rdy, bus.m_req_rdy}, (win == 1) ? 2'b01 : 2'b10);
        chk("grant_latency", k, 0);
        pref      = 1 - win;
        owner     = win;
        pend[win] = 1'b0;
        tick();
        drive_reqs();
        bus.l15_core_ack        = 1'b1;
        bus.l15_core_header_ack = 1'b1;
        sample();
        chk("req_fields", {bus.core_l15_val, bus.core_l15_rqtype, bus.core_l15_size,
                           bus.core_l15_address, bus.core_l15_data},
                          {1'b1, c_rq[win], c_sz[win], c_ad[win], c_dt[win]});
        chk("no_rdy_in_req", {bus.f_req_rdy, bus.m_req_rdy}, 2'b00);
        tick();
        bus.l15_core_ack        = 1'b0;
        bus.l15_core_header_ack = 1'b0;
        sample();
        chk("val_drop_wait", bus.core_l15_val, 1'b0);
    endtask

    // One L1.5 response beat; checks the consume pulse and the client response next cycle
    task automatic respond(input logic [3:0] rt, input logic [63:0] d0, input logic [63:0] d1,
                           input bit exp_resp);
        tick();
        bus.l15_core_val        = 1'b1;
        bus.l15_core_returntype = rt;
        bus.l15_core_data_0     = d0;
        bus.l15_core_data_1     = d1;
        sample();
        chk("resp_ack", bus.core_l15_req_ack, 1'b1);
        tick();
        bus.l15_core_val = 1'b0;
        sample();
        if (exp_resp) begin
            chk("resp_out", {bus.f_resp_val, bus.m_resp_val, bus.resp_returntype,
                             bus.resp_data_0, bus.resp_data_1, bus.resp_err},
                            {owner == 0, owner == 1, rt, d0, d1, 1'b0});
        end else begin
            chk("resp_none", {bus.f_resp_val, bus.m_resp_val}, 2'b00);
        end
        chk("err_sticky", bus.err_sticky, exp_sticky);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        int k;
        logic [5:0] rq;

        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            pend[c] = 1'b0;
            c_rq[c] = '0;
            c_sz[c] = '0;
            c_ad[c] = '0;
            c_dt[c] = '0;
        end
        drive_reqs();
        l15_idle();
        pref       = 1;
        owner      = 0;
        exp_sticky = 1'b0;

        // Reset state
        do_reset();
        chk("reset_outs", all_outs(), 256'd0);

        // Single data-memory load at 0x40
        new_req(1, LOAD_RQ, 32'h40);
        grant();
        respond(LOAD_RET, 64'h1122334455667788, rnd64(), 1'b1);

        // Simultaneous pair from reset: mem first, then fetch wins the next pair
        do_reset();
        new_req(0, IMISS_RQ, 32'h1000);
        new_req(1, LOAD_RQ, 32'h80);
        grant();
        respond(LOAD_RET, rnd64(), rnd64(), 1'b1);
        new_req(1, STORE_RQ, 32'h84);
        grant();
        respond(IFILL_RET, rnd64(), rnd64(), 1'b1);

        // INT_RET dropped, then ST_ACK completes the store
        grant();
        respond(INT_RET, rnd64(), rnd64(), 1'b0);
        respond(ST_ACK, rnd64(), rnd64(), 1'b1);

        // Unexpected return type: dropped, sticky error, still waiting
        new_req(1, LOAD_RQ, 32'hC0);
        grant();
        exp_sticky = 1'b1;
        respond(4'h2, rnd64(), rnd64(), 1'b0);
        respond(LOAD_RET, rnd64(), rnd64(), 1'b1);

        // Timeout after 8 cycles in WAIT, then a late response is dropped
        new_req(0, IMISS_RQ, 32'h2000);
        grant();
        k = 0;
        do begin
            tick();
            sample();
            k++;
        end while (!(bus.f_resp_val || bus.m_resp_val) && k < 20);
        chk("timeout_cycles", k, 8);
        chk("timeout_resp", {bus.f_resp_val, bus.m_resp_val, bus.resp_err,
                             bus.resp_data_0, bus.resp_data_1},
                            {1'b1, 1'b0, 1'b1, 64'd0, 64'd0});
        chk("timeout_sticky", bus.err_sticky, 1'b1);
        respond(LOAD_RET, rnd64(), rnd64(), 1'b0);

        // Reset while waiting: everything clears, a stray response is dropped
        new_req(1, LOAD_RQ, 32'h3000);
        grant();
        tick();
        rst = 1'b1;
        sample();
        tick();
        rst = 1'b0;
        sample();
        pref       = 1;
        exp_sticky = 1'b0;
        chk("rst_wait_outs", all_outs(), 256'd0);
        respond(LOAD_RET, rnd64(), rnd64(), 1'b0);

        // Randomized rounds against the model
        for (int r = 0; r < 40; r++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
                    case ($urandom_range(0, 2))
                        0:       rq = LOAD_RQ;
                        1:       rq = STORE_RQ;
                        default: rq = IMISS_RQ;
                    endcase
                    new_req(c, rq, $urandom);
                end
            end
            if (!pend[0] && !pend[1]) begin
                new_req(int'($urandom_range(0, 1)), LOAD_RQ, $urandom);
            end
            grant();
            if ($urandom_range(0, 3) == 0) begin
                respond(INT_RET, rnd64(), rnd64(), 1'b0);
            end
            respond(exp_ret(c_rq[owner]), rnd64(), rnd64(), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
